// File: rtl/ula_det_ctrl.sv
// Request-side controller for the ULA determinant engine.
// Latches a request matrix, runs the engine's level start/done handshake,
// captures the 8-bit determinant and returns it as a one-cycle response.
// Both the RUN and DRAIN phases have their own timeout so a hung engine
// cannot wedge the coprocessor.
module ula_det_ctrl #(
  // Legal range 2..65535; the 16-bit counter holds TIMEOUT_CYCLES-1.
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic [199:0] req_matrix,
  output logic         busy,
  output logic         rsp_valid,
  output logic [7:0]   rsp_det,
  output logic         rsp_timeout,
  output logic [199:0] eng_matrix,
  output logic         eng_start,
  input  logic         eng_done,
  input  logic [7:0]   eng_det
);

  localparam logic [15:0] CntMax = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StResp
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [199:0]   matrix_q, matrix_d;
  logic [7:0]     det_q, det_d;
  logic           timeout_q, timeout_d;

  // State and datapath registers; async reset returns everything to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      matrix_q  <= '0;
      det_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      matrix_q  <= matrix_d;
      det_q     <= det_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic for the handshake sequence and response capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    matrix_d  = matrix_q;
    det_d     = det_q;
    timeout_d = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          matrix_d  = req_matrix;
          det_d     = '0;
          timeout_d = 1'b0;
          state_d   = StLoad;
        end
      end

      // One settle cycle so eng_matrix is stable before start rises.
      StLoad: begin
        cnt_d   = '0;
        state_d = StRun;
      end

      // Done takes priority over a timeout landing on the same edge.
      StRun: begin
        if (eng_done) begin
          det_d     = eng_det;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = StDrain;
        end else if (cnt_q == CntMax) begin
          det_d     = '0;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StDrain;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // Wait for the engine to release done; a stuck done keeps the captured det.
      StDrain: begin
        if (!eng_done) begin
          state_d = StResp;
        end else if (cnt_q == CntMax) begin
          timeout_d = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registered state, so they are glitch-free per cycle.
  always_comb begin
    busy        = (state_q != StIdle);
    rsp_valid   = (state_q == StResp);
    eng_start   = (state_q == StRun);
    eng_matrix  = matrix_q;
    rsp_det     = det_q;
    rsp_timeout = timeout_q;
  end

endmodule

// File: doc/ula_det_ctrl.md
# ula_det_ctrl

Request-side controller for the ULA determinant engine (5x5/4x4 determinant units using the level start/done handshake). It accepts a one-cycle request carrying a 200-bit matrix and holds that matrix stable toward the engine. It drives the engine's level `start`, waits for `done`, captures the 8-bit result, then completes the return-to-idle half of the handshake. Results go back to the coprocessor datapath as a one-cycle response, with timeout protection against a hung engine.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum cycles in RUN, and separately in DRAIN, before abort; legal range 2..65535.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  one-cycle request; accepted only while `busy`=0.
- `req_matrix`  in  200  matrix; element (row r, col c) at bits [40r+8c +: 8], r,c in 0..4.
- `busy`  out  1  high from accept until the response cycle ends.
- `rsp_valid`  out  1  one-cycle pulse: `rsp_det` and `rsp_timeout` valid.
- `rsp_det`  out  8  captured determinant (mod 256); 0 on timeout.
- `rsp_timeout`  out  1  set if the transaction aborted.
- `eng_matrix`  out  200  registered copy of `req_matrix` toward the engine.
- `eng_start`  out  1  level start to the engine.
- `eng_done`  in  1  level done from the engine; held until `eng_start` falls.
- `eng_det`  in  8  engine result; valid while `eng_done`=1.

## Operation
- States: IDLE, LOAD, RUN, DRAIN, RESP.
- IDLE: `busy`=0, `eng_start`=0. When `req`=1 is sampled, capture `req_matrix` into `eng_matrix`, set `busy`=1, and go to LOAD.
- LOAD: one cycle, so `eng_matrix` is stable before start. Set `eng_start`=1, clear the timeout counter, and go to RUN.
- RUN: hold `eng_start`=1; the counter increments each cycle.
  - If `eng_done`=1 is sampled: `rsp_det`<=`eng_det`, `rsp_timeout`<=0, `eng_start`<=0, clear the counter, go to DRAIN.
  - Else if the counter equals TIMEOUT_CYCLES-1: `rsp_det`<=0, `rsp_timeout`<=1, `eng_start`<=0, clear the counter, go to DRAIN.
  - If done and the timeout condition are sampled on the same edge, done wins (normal completion).
- DRAIN: `eng_start`=0; wait for the engine to drop done.
  - If `eng_done`=0 is sampled, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 with `eng_done` still 1: `rsp_timeout`<=1, go to RESP. `rsp_det` keeps its captured value.
- RESP: `rsp_valid`=1 for exactly one cycle, then go to IDLE. `busy` deasserts on the same edge `rsp_valid` falls.
- `req` is ignored in every state except IDLE; it is not queued.
- `eng_matrix`, `rsp_det` and `rsp_timeout` hold their values until the next accepted request or reset. Accepting a request clears `rsp_timeout` and `rsp_det` to 0.
- No arithmetic is performed here. `eng_det` is passed through unmodified as an 8-bit wrap-around value.
- Reset (async, at any time including mid-RUN): state IDLE and every output 0, i.e. `busy`, `rsp_valid`, `rsp_det`, `rsp_timeout`, `eng_start` and `eng_matrix`. `eng_start` drops immediately, which returns the engine to its idle state.

## Timing
- `req` sampled at edge N: `busy`=1 and `eng_matrix` updated after N; `eng_start`=1 after N+1.
- `eng_done` sampled high at edge M: `eng_start`=0 and `rsp_det` valid after M.
- `eng_done` sampled low at edge K>M: `rsp_valid`=1 after K; `rsp_valid`=0 and `busy`=0 after K+1.
- A new `req` is accepted at the earliest at edge K+2.
- Request-to-response overhead is engine latency plus 3 cycles with a 1-cycle done release.
- Timeout in RUN: with no done, `eng_start` falls after edge N+1+TIMEOUT_CYCLES.
- `eng_done` is assumed synchronous to `clk`; no synchronizer is required.

## Test plan
- Normal: behavioral engine, latency 12, `eng_det`=8'hF3 -> exactly one `rsp_valid` pulse with `rsp_det`=F3, `rsp_timeout`=0, `eng_start` high for 12 cycles, `busy` high from accept to the end of the pulse.
- Back-to-back: two requests (det 5 then det 8'h80), second `req` at the first legal edge -> two responses, 5 then 80, each `eng_matrix` equal to its request and stable for the whole RUN.
- Busy rejection: pulse `req` with a different matrix during RUN and during RESP -> `eng_matrix` unchanged, one response only.
- Timeout: TIMEOUT_CYCLES=16, engine never asserts done -> `eng_start` high 16 cycles, response with `rsp_det`=0 and `rsp_timeout`=1. A following normal request returns `rsp_timeout`=0.
- Done on timeout edge: engine asserts done exactly on the 16th RUN cycle -> normal completion with `rsp_det`=`eng_det` and `rsp_timeout`=0. Done stuck high in DRAIN -> response after 16 cycles with `rsp_timeout`=1 and the captured det.
- Reset mid-RUN: assert `rst_n`=0 asynchronously mid-cycle -> all outputs 0 immediately and no `rsp_valid`. After release, a request completes normally.
